// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled counter family.
package counter_pkg;

  // Count direction encoding on the dir input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Prescaler base periods: short for simulation, 128 Hz tick from 50 MHz on the board.
  localparam int DIV_BASE_SIM   = 2;
  localparam int DIV_BASE_BOARD = 50_000_000 / 128;

  // Tick period in clock cycles for a given base period and speed select.
  function automatic int unsigned period(input int unsigned div_base, input int unsigned sel);
    return div_base << sel;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tick generator: emits a one-cycle en strobe every DIV_BASE << sw cycles while run=1.
// Strobe contract: en is a pulse with no backpressure; a consumer acts on every
// cycle where en=1 and there is no ready/acknowledge path back into this block.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int DIV_BASE = DIV_BASE_SIM,
  parameter int SEL_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr,
  input  logic [SEL_W-1:0] sw,
  output logic             en
);

  // Wide enough to hold the longest period minus one with a spare bit.
  localparam int PRE_W = $clog2(DIV_BASE << (2**SEL_W - 1)) + 1;

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic [31:0]      period_m1;
  logic [31:0]      pre_cnt_ext;
  logic             at_end;

  // Period end decode; P is re-evaluated every cycle so a shorter sw fires at once.
  always_comb begin
    period_m1   = period(DIV_BASE, 32'(sw)) - 32'd1;
    pre_cnt_ext = 32'(pre_cnt_q);
    at_end      = (pre_cnt_ext >= period_m1);
    en          = run & ~reset & at_end;
  end

  // Next prescaler value: clear wins, then wrap/increment while running, else hold.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (run) begin
      if (at_end) pre_cnt_d = '0;
      else        pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  // Prescaler register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Up/down modulo counter advanced by a selectable-rate prescaler tick.
// en and tc are one-cycle strobes (no handshake); q changes on the edge ending an en cycle.
module prescaled_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SEL_W    = 3,
  parameter int DIV_BASE = DIV_BASE_SIM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sw,
  input  logic             run,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_wrap;

  // Load also restarts the prescaler so the first tick after it is a full period away.
  tick_prescaler #(
    .DIV_BASE (DIV_BASE),
    .SEL_W    (SEL_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (load),
    .sw    (sw),
    .en    (en)
  );

  // Wrap condition for the current direction; q above limit counts as wrapping.
  always_comb begin
    at_wrap = 1'b0;
    if (dir == DIR_UP) at_wrap = (count_q >= limit);
    else               at_wrap = (count_q == '0);
    tc = en & at_wrap;
  end

  // Next count: load beats the tick; down mode out of range jumps to limit.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count_q >= limit) count_d = '0;
        else                  count_d = count_q + WIDTH'(1);
      end else begin
        if (count_q == '0 || count_q > limit) count_d = limit;
        else                                  count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign q = count_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench for prescaled_updown_counter with a tick scoreboard.
module tb_prescaled_updown_counter;

  localparam int WIDTH    = 4;
  localparam int SEL_W    = 3;
  localparam int DIV_BASE = 2;
  localparam int W        = WIDTH + 1;

  logic             clk;
  logic             reset;
  logic [SEL_W-1:0] sw;
  logic             run;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             tc;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];

  prescaled_updown_counter #(
    .WIDTH    (WIDTH),
    .SEL_W    (SEL_W),
    .DIV_BASE (DIV_BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .run      (run),
    .dir      (dir),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .q        (q),
    .tc       (tc)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic exp_tc, input logic [WIDTH-1:0] exp_val);
    exp_q.push_back({exp_tc, exp_val});
  endtask

  task automatic drain(output int cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d ticks outstanding after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    cyc = n;
  endtask

  // Scoreboard monitor: every tick must match the next expected {tc, q}
  always @(negedge clk) begin
    if (en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tick: got en=1 q=%0d expected no tick", q);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("tick_q", 32'(q), 32'(e[WIDTH-1:0]));
        check("tick_tc", 32'(tc), 32'(e[WIDTH]));
      end
    end
  end

  // Directed stimulus
  initial begin
    int cyc;
    reset = 1'b0; sw = '0; run = 1'b1; dir = 1'b0; limit = 4'd15;
    load = 1'b0; load_val = '0;

    // 1: reset mid-cycle, then a full up count 0..15,0..15 at P=2
    #2 reset = 1'b1;
    #5;
    check("reset_q", 32'(q), 0);
    check("reset_en", 32'(en), 0);
    check("reset_tc", 32'(tc), 0);
    for (int k = 0; k < 32; k++) push(k % 16 == 15, WIDTH'(k % 16));
    #5 reset = 1'b0;
    drain(cyc);
    check("t1_q_after", 32'(q), 0);

    // 2: P=16, ten ticks in 160 cycles, hold, then resume the partial period
    sw = 3'd3;
    for (int k = 0; k < 10; k++) push(1'b0, WIDTH'(k));
    drain(cyc);
    check("t2_cycles", cyc, 160);
    check("t2_q", 32'(q), 10);
    step(5);
    run = 1'b0;
    step(50);
    check("t2_hold_q", 32'(q), 10);
    check("t2_hold_en", 32'(en), 0);
    run = 1'b1;
    push(1'b0, 4'd10);
    drain(cyc);
    check("t2_resume_cycles", cyc, 11);
    check("t2_resume_q", 32'(q), 11);

    // 3: down count with limit 9, then limit cut below q
    sw = '0; dir = 1'b1; limit = 4'd9; load_val = 4'd0; load = 1'b1;
    step(1);
    load = 1'b0;
    check("t3_load_q", 32'(q), 0);
    push(1'b1, 4'd0);
    for (int v = 9; v >= 1; v--) push(1'b0, WIDTH'(v));
    push(1'b1, 4'd0);
    push(1'b0, 4'd9);
    drain(cyc);
    check("t3_q8", 32'(q), 8);
    limit = 4'd5;
    push(1'b0, 4'd8);
    drain(cyc);
    check("t3_jump_limit", 32'(q), 5);

    // 4: up mode q=12, limit lowered to 7 wraps to 0 with tc
    dir = 1'b0; limit = 4'd15; load_val = 4'd12; load = 1'b1;
    step(1);
    load = 1'b0;
    check("t4_load_q", 32'(q), 12);
    limit = 4'd7;
    push(1'b1, 4'd12);
    drain(cyc);
    check("t4_wrap_q", 32'(q), 0);

    // 5: P=256 mid-period, switch to P=4 fires immediately then every 4
    sw = 3'd7;
    step(100);
    check("t5_no_tick_q", 32'(q), 0);
    push(1'b0, 4'd0);
    sw = 3'd1;
    drain(cyc);
    check("t5_immediate", cyc, 1);
    push(1'b0, 4'd1);
    push(1'b0, 4'd2);
    push(1'b0, 4'd3);
    drain(cyc);
    check("t5_period4", cyc, 12);
    check("t5_q", 32'(q), 4);

    // 6: load while held, first tick one period later, async reset
    step(2);
    run = 1'b0; sw = '0; load_val = 4'd6; load = 1'b1;
    step(1);
    load = 1'b0;
    check("t6_load_q", 32'(q), 6);
    run = 1'b1; dir = 1'b0;
    #1;
    check("t6_no_en_after_load", 32'(en), 0);
    push(1'b0, 4'd6);
    drain(cyc);
    check("t6_first_tick", cyc, 2);
    check("t6_q", 32'(q), 7);
    step(1);
    check("t6_en_before_reset", 32'(en), 1);
    reset = 1'b1;
    #1;
    check("t6_async_q", 32'(q), 0);
    check("t6_async_en", 32'(en), 0);
    check("t6_async_tc", 32'(tc), 0);
    limit = 4'd0;
    #1 reset = 1'b0;

    // limit=0 keeps q at 0 with tc on every tick
    push(1'b1, 4'd0);
    push(1'b1, 4'd0);
    drain(cyc);
    check("lim0_q", 32'(q), 0);

    // Final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
